song_select_ctrl: RTL and testbench

Playback controller that sits directly upstream of the song reader and note distributor in `music_player`. It turns keypad song selections, a play/pause button and the song reader's `song_done` into the `play`, `reset_player` and `song` controls that drive the playback chain. On every song change it holds `reset_player` high for a fixed number of cycles before asserting `play`, so the song ROM address and note state settle first.

---
 rtl/music_pkg.sv | 27 ++
 rtl/hold_timer.sv | 30 +++
 rtl/song_select_ctrl.sv | 130 +++++++++++++
 tb/tb_song_select_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the music player playback chain.
package music_pkg;

  localparam int unsigned SONG_W = 4;
  localparam int unsigned HOLD_W = 4;

  localparam int unsigned DEFAULT_NUM_SONGS    = 16;
  localparam int unsigned DEFAULT_RESET_CYCLES = 2;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPlaying,
    StPaused,
    StDone
  } play_state_e;

  // Next song index, wrapping from the last valid song back to 0.
  function automatic logic [SONG_W-1:0] next_song(input logic [SONG_W-1:0] cur,
                                                  input int unsigned num_songs);
    if (cur == SONG_W'(num_songs - 1)) begin
      return '0;
    end
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with a zero flag; times the reset_player hold in LOAD.
module hold_timer
  import music_pkg::*;
#(
  parameter int unsigned CNT_W = HOLD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/song_select_ctrl.sv
// Playback controller: turns keypad selections, play/pause and song_done into
// play / reset_player / song for the song reader and note distributor.
// Optional feature macro: SONG_AUTO_ADVANCE_EN (song_done advances to the next song).
module song_select_ctrl
  import music_pkg::*;
#(
  parameter int unsigned NUM_SONGS    = DEFAULT_NUM_SONGS,
  parameter int unsigned RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SONG_W-1:0] keypad_value,
  input  logic              keypad_strobe,
  input  logic              play_button,
  input  logic              color_changing,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic              busy
);

  // Counter reaching zero marks the last LOAD cycle, hence RESET_CYCLES-1.
  localparam logic [HOLD_W-1:0] HoldInit = HOLD_W'(RESET_CYCLES - 1);

  play_state_e       state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d;
  logic              play_q, play_d;
  logic              rst_player_q, rst_player_d;
  logic              busy_q, busy_d;

  logic key_accept;
  logic timer_load;
  logic timer_dec;
  logic timer_zero;

  // Widen by one bit so NUM_SONGS=16 accepts every key code.
  assign key_accept = keypad_strobe && !color_changing &&
                      ({1'b0, keypad_value} < (SONG_W + 1)'(NUM_SONGS));

  hold_timer #(
    .CNT_W (HOLD_W)
  ) u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (HoldInit),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      song_q       <= '0;
      play_q       <= 1'b0;
      rst_player_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      song_q       <= song_d;
      play_q       <= play_d;
      rst_player_q <= rst_player_d;
      busy_q       <= busy_d;
    end
  end

  // Next state: accepted key beats song_done, which beats play_button.
  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    if (key_accept) begin
      state_d    = StLoad;
      song_d     = keypad_value;
      timer_load = 1'b1;
    end else begin
      case (state_q)
        StLoad: begin
          if (timer_zero) begin
            state_d = StPlaying;
          end else begin
            timer_dec = 1'b1;
          end
        end
        StPlaying: begin
          if (song_done) begin
`ifdef SONG_AUTO_ADVANCE_EN
            song_d     = next_song(song_q, NUM_SONGS);
            state_d    = StLoad;
            timer_load = 1'b1;
`else
            state_d = StDone;
`endif
          end else if (play_button) begin
            state_d = StPaused;
          end
        end
        StPaused: begin
          if (play_button) begin
            state_d = StPlaying;
          end
        end
        StIdle, StDone: begin
          // Replay the current song.
          if (play_button) begin
            state_d    = StLoad;
            timer_load = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    play_d       = (state_d == StPlaying);
    rst_player_d = (state_d == StLoad);
    busy_d       = (state_d == StLoad);
  end

  assign play         = play_q;
  assign reset_player = rst_player_q;
  assign song         = song_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_song_select_ctrl.sv
// Self-checking bench for song_select_ctrl: directed vector table plus random
// stimulus against a behavioural model, on two parameterisations.
module tb_song_select_ctrl;

`ifdef SONG_AUTO_ADVANCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_DONE  = 4;

  typedef struct {
    int mode;
    int song;
    int hl;   // reset_player cycles still to show, counting the current one
  } model_t;

  typedef struct {
    bit         rst;
    bit         strb;
    logic [3:0] val;
    bit         btn;
    bit         col;
    bit         done;
    bit         e_play;
    bit         e_rp;
    logic [3:0] e_song;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] keypad_value;
  logic       keypad_strobe;
  logic       play_button;
  logic       color_changing;
  logic       song_done;

  logic       play_a, rp_a, busy_a;
  logic [3:0] song_a;
  logic       play_b, rp_b, busy_b;
  logic [3:0] song_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  model_t ma, mb;

  song_select_ctrl #(
    .NUM_SONGS    (16),
    .RESET_CYCLES (2)
  ) u_dut_a (
    .clk            (clk),
    .reset          (reset),
    .keypad_value   (keypad_value),
    .keypad_strobe  (keypad_strobe),
    .play_button    (play_button),
    .color_changing (color_changing),
    .song_done      (song_done),
    .play           (play_a),
    .reset_player   (rp_a),
    .song           (song_a),
    .busy           (busy_a)
  );

  song_select_ctrl #(
    .NUM_SONGS    (10),
    .RESET_CYCLES (3)
  ) u_dut_b (
    .clk            (clk),
    .reset          (reset),
    .keypad_value   (keypad_value),
    .keypad_strobe  (keypad_strobe),
    .play_button    (play_button),
    .color_changing (color_changing),
    .song_done      (song_done),
    .play           (play_b),
    .reset_player   (rp_b),
    .song           (song_b),
    .busy           (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one call per sampling edge.
  function automatic model_t model_step(model_t m, int ns, int rc, bit rst, bit strb, int val,
                                        bit btn, bit col, bit done);
    model_t n;
    n = m;
    if (rst) begin
      n.mode = M_IDLE;
      n.song = 0;
      n.hl   = 0;
      return n;
    end
    if (strb && !col && val < ns) begin
      n.mode = M_LOAD;
      n.song = val;
      n.hl   = rc;
      return n;
    end
    case (m.mode)
      M_LOAD: begin
        n.hl = m.hl - 1;
        if (n.hl == 0) n.mode = M_PLAY;
      end
      M_PLAY: begin
        if (done) begin
          if (AUTO) begin
            n.song = (m.song + 1) % ns;
            n.mode = M_LOAD;
            n.hl   = rc;
          end else begin
            n.mode = M_DONE;
          end
        end else if (btn) begin
          n.mode = M_PAUSE;
        end
      end
      M_PAUSE: if (btn) n.mode = M_PLAY;
      default: begin
        if (btn) begin
          n.mode = M_LOAD;
          n.hl   = rc;
        end
      end
    endcase
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_model(string tag, logic p, logic r, logic b, logic [3:0] s, model_t m);
    chk({tag, ".play"}, 32'(p), 32'(m.mode == M_PLAY));
    chk({tag, ".reset_player"}, 32'(r), 32'(m.mode == M_LOAD));
    chk({tag, ".busy"}, 32'(b), 32'(m.mode == M_LOAD));
    chk({tag, ".song"}, 32'(s), 32'(m.song));
  endtask

  // Drive one cycle of inputs, advance both models at the edge, check at negedge.
  task automatic cycle(bit rst, bit strb, logic [3:0] val, bit btn, bit col, bit done);
    reset          = rst;
    keypad_strobe  = strb;
    keypad_value   = val;
    play_button    = btn;
    color_changing = col;
    song_done      = done;
    @(posedge clk);
    ma = model_step(ma, 16, 2, rst, strb, int'(val), btn, col, done);
    mb = model_step(mb, 10, 3, rst, strb, int'(val), btn, col, done);
    @(negedge clk);
    cyc++;
    chk_model("a", play_a, rp_a, busy_a, song_a, ma);
    chk_model("b", play_b, rp_b, busy_b, song_b, mb);
  endtask

  vec_t tbl[26];

  initial begin
    reset          = 1'b0;
    keypad_value   = '0;
    keypad_strobe  = 1'b0;
    play_button    = 1'b0;
    color_changing = 1'b0;
    song_done      = 1'b0;
    ma = '{mode: M_IDLE, song: 0, hl: 0};
    mb = '{mode: M_IDLE, song: 0, hl: 0};

    //            rst strb val  btn col done  play rp  song  (dut a: 16 songs, hold 2)
    tbl[0]  = '{1, 0, 4'd0,  0, 0, 0,  0, 0, 4'd0};
    tbl[1]  = '{0, 0, 4'd0,  0, 0, 0,  0, 0, 4'd0};
    tbl[2]  = '{0, 1, 4'd5,  0, 0, 0,  0, 1, 4'd5};
    tbl[3]  = '{0, 0, 4'd0,  0, 0, 0,  0, 1, 4'd5};
    tbl[4]  = '{0, 0, 4'd0,  0, 0, 0,  1, 0, 4'd5};
    tbl[5]  = '{0, 0, 4'd0,  1, 0, 0,  0, 0, 4'd5};
    tbl[6]  = '{0, 0, 4'd0,  0, 0, 0,  0, 0, 4'd5};
    tbl[7]  = '{0, 0, 4'd0,  1, 0, 0,  1, 0, 4'd5};
    tbl[8]  = '{0, 1, 4'd9,  0, 1, 0,  1, 0, 4'd5};
    tbl[9]  = '{0, 1, 4'd15, 0, 0, 0,  0, 1, 4'd15};
    tbl[10] = '{0, 0, 4'd0,  0, 0, 0,  0, 1, 4'd15};
    tbl[11] = '{0, 0, 4'd0,  0, 0, 0,  1, 0, 4'd15};
    tbl[12] = '{0, 0, 4'd0,  0, 0, 1,  0, AUTO, AUTO ? 4'd0 : 4'd15};
    tbl[13] = '{0, 0, 4'd0,  0, 0, 0,  0, AUTO, AUTO ? 4'd0 : 4'd15};
    tbl[14] = '{0, 0, 4'd0,  1, 0, 0,  AUTO, !AUTO, AUTO ? 4'd0 : 4'd15};
    tbl[15] = '{0, 0, 4'd0,  0, 0, 0,  AUTO, !AUTO, AUTO ? 4'd0 : 4'd15};
    tbl[16] = '{0, 0, 4'd0,  0, 0, 0,  1, 0, AUTO ? 4'd0 : 4'd15};
    tbl[17] = '{0, 1, 4'd3,  0, 0, 1,  0, 1, 4'd3};
    tbl[18] = '{0, 0, 4'd0,  0, 0, 0,  0, 1, 4'd3};
    tbl[19] = '{0, 1, 4'd7,  0, 0, 0,  0, 1, 4'd7};
    tbl[20] = '{0, 0, 4'd0,  0, 0, 0,  0, 1, 4'd7};
    tbl[21] = '{1, 0, 4'd0,  0, 0, 0,  0, 0, 4'd0};
    tbl[22] = '{0, 0, 4'd0,  1, 0, 0,  0, 1, 4'd0};
    tbl[23] = '{0, 0, 4'd0,  0, 0, 0,  0, 1, 4'd0};
    tbl[24] = '{0, 0, 4'd0,  0, 0, 0,  1, 0, 4'd0};
    tbl[25] = '{0, 0, 4'd0,  1, 0, 1,  0, AUTO, AUTO ? 4'd1 : 4'd0};

    for (int i = 0; i < 26; i++) begin
      cycle(tbl[i].rst, tbl[i].strb, tbl[i].val, tbl[i].btn, tbl[i].col, tbl[i].done);
      chk($sformatf("vec%0d.play", i), 32'(play_a), 32'(tbl[i].e_play));
      chk($sformatf("vec%0d.reset_player", i), 32'(rp_a), 32'(tbl[i].e_rp));
      chk($sformatf("vec%0d.busy", i), 32'(busy_a), 32'(tbl[i].e_rp));
      chk($sformatf("vec%0d.song", i), 32'(song_a), 32'(tbl[i].e_song));
    end

    // Out-of-range key for the 10-song instance: 12 accepted by a, ignored by b.
    cycle(1, 0, 4'd0, 0, 0, 0);
    cycle(0, 1, 4'd12, 0, 0, 0);
    chk("key12.song_a", 32'(song_a), 32'd12);
    chk("key12.song_b", 32'(song_b), 32'd0);
    chk("key12.busy_b", 32'(busy_b), 32'd0);

    // Hold length of the 3-cycle instance: key 4, then reset_player for 3 cycles.
    cycle(0, 1, 4'd4, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold3.rp_b%0d", k), 32'(rp_b), 32'd1);
      chk($sformatf("hold3.play_b%0d", k), 32'(play_b), 32'd0);
      cycle(0, 0, 4'd0, 0, 0, 0);
    end
    chk("hold3.play_b_on", 32'(play_b), 32'd1);

    // Random stimulus against the model.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(99) == 0, $urandom_range(7) == 0, 4'($urandom_range(15)),
            $urandom_range(5) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0);
      chk("excl.a", 32'(play_a && rp_a), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
